mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) for a single-port memory with a fixed read
// latency. Define MEM_ARB_RR_EN for round-robin arbitration; the default is data-first priority.
module mem_arbiter #(
  parameter int unsigned AW  = 10,
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} state_e;

  localparam logic [2:0] LatCnt = 3'(LAT);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q;
  logic          own_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] f_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          pick_d;

`ifdef MEM_ARB_RR_EN
  // last_q records the grantee of the most recent completed access; the other side wins a tie.
  logic last_q;
  assign pick_d = d_req & (~f_req | ~last_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (f_req | d_req) state_d = StGrant;
      StGrant: state_d = StWait;
      StWait:  if (cnt_q <= 3'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      own_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (f_req | d_req) begin
            own_q   <= pick_d;
            addr_q  <= pick_d ? d_addr : f_addr;
            we_q    <= pick_d & d_we;
            wdata_q <= pick_d ? d_wdata : '0;
          end
        end
        StGrant: cnt_q <= LatCnt;
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          // Final WAIT cycle: read data is valid now; writes leave both rdata registers alone.
          if (cnt_q <= 3'd1 && !we_q) begin
            if (own_q) d_rdata_q <= mem_rdata;
            else       f_rdata_q <= mem_rdata;
          end
        end
        StResp: begin
`ifdef MEM_ARB_RR_EN
          last_q <= own_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign owner     = busy & own_q;
  assign mem_en    = (state_q == StGrant);
  assign mem_we    = (state_q == StGrant) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign f_ack     = (state_q == StResp) & ~own_q;
  assign d_ack     = (state_q == StResp) & own_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single accesses plus hand-written sequences
// for ties, reset mid-access, back-to-back requests and a LAT=3 instance.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] mem_data;

  logic [DW-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          f_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;

  logic          f_req3 = 1'b0;
  logic          d_req3;
  logic [DW-1:0] f_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic          f_ack3, d_ack3, mem_en3, mem_we3, busy3, owner3;
  logic [AW-1:0] mem_addr3;

  // Memory models: read data is valid only in the cycle LAT cycles after mem_en, junk otherwise.
  logic       v1  = 1'b0;
  logic [2:0] sr3 = 3'b000;
  always @(posedge clk) begin
    v1  <= mem_en & ~mem_we;
    sr3 <= {sr3[1:0], mem_en3 & ~mem_we3};
  end
  assign mem_rdata  = v1     ? mem_data : 16'hDEAD;
  assign mem_rdata3 = sr3[2] ? mem_data : 16'hDEAD;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .f_req(f_req3), .f_addr(f_addr), .f_rdata(f_rdata3), .f_ack(f_ack3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_ack(d_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts from IDLE with inputs driven; returns at the negedge inside RESP.
  task automatic run_access(input string tag, input logic eown, input logic [AW-1:0] ea,
                            input logic ewe, input logic [DW-1:0] ewd);
    int ens;
    int cyc;
    bit got;
    ens = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 12) begin
      step();
      cyc++;
      if (mem_en) begin
        ens++;
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(ea));
        check({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
        check({tag, " owner"}, 32'(owner), 32'(eown));
        if (ewe) check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(ewd));
      end
      if (f_ack || d_ack) begin
        got = 1'b1;
        check({tag, " ack_cycle"}, 32'(cyc), 32'd3);
        check({tag, " d_ack"}, 32'(d_ack), 32'(eown));
        check({tag, " f_ack"}, 32'(f_ack), 32'(!eown));
      end
    end
    if (!got) check({tag, " ack_timeout"}, 32'd0, 32'd1);
    check({tag, " mem_en_count"}, 32'(ens), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " owner"}, 32'(owner), 32'd0);
    check({tag, " acks"}, 32'({f_ack, d_ack}), 32'd0);
    check({tag, " mem_en_we"}, 32'({mem_en, mem_we}), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, " f_rdata"}, 32'(f_rdata), 32'd0);
    check({tag, " d_rdata"}, 32'(d_rdata), 32'd0);
  endtask

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_data;
    logic          e_own;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_f;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs[6];
  logic exp_tie[4];

  initial begin
    // Hand-computed; the tie in entry 3 goes to fetch in round-robin mode (data served last).
    vecs[0] = '{1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 16'h0000, 16'hA5A5,
                1'b0, 10'h010, 1'b0, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 16'h1234, 16'h9999,
                1'b1, 10'h200, 1'b1, 16'hA5A5, 16'h0000};
    vecs[2] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h0FF, 16'h0000, 16'h0F0F,
                1'b1, 10'h0FF, 1'b0, 16'hA5A5, 16'h0F0F};
    if (!Rr) begin
      vecs[3] = '{1'b1, 10'h011, 1'b1, 1'b0, 10'h300, 16'h0000, 16'h5A5A,
                  1'b1, 10'h300, 1'b0, 16'hA5A5, 16'h5A5A};
      vecs[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 16'hFFFF, 16'h6666,
                  1'b1, 10'h3FF, 1'b1, 16'hA5A5, 16'h5A5A};
      vecs[5] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h8001,
                  1'b0, 10'h3FF, 1'b0, 16'h8001, 16'h5A5A};
      exp_tie = '{1'b1, 1'b1, 1'b1, 1'b1};
    end else begin
      vecs[3] = '{1'b1, 10'h011, 1'b1, 1'b0, 10'h300, 16'h0000, 16'h5A5A,
                  1'b0, 10'h011, 1'b0, 16'h5A5A, 16'h0F0F};
      vecs[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 16'hFFFF, 16'h6666,
                  1'b1, 10'h3FF, 1'b1, 16'h5A5A, 16'h0F0F};
      vecs[5] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h8001,
                  1'b0, 10'h3FF, 1'b0, 16'h8001, 16'h0F0F};
      exp_tie = '{1'b1, 1'b0, 1'b1, 1'b0};
    end

    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_req3 = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_data = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      f_req = vecs[i].f_req; f_addr = vecs[i].f_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      mem_data = vecs[i].mem_data;
      run_access($sformatf("vec%0d", i), vecs[i].e_own, vecs[i].e_addr, vecs[i].e_we,
                 vecs[i].d_wdata);
      check($sformatf("vec%0d f_rdata", i), 32'(f_rdata), 32'(vecs[i].e_f));
      check($sformatf("vec%0d d_rdata", i), 32'(d_rdata), 32'(vecs[i].e_d));
      f_req = 1'b0; d_req = 1'b0;
      step();
      check($sformatf("vec%0d idle", i), 32'({busy, owner, mem_en}), 32'd0);
    end

    // Fresh reset so the first tie sees the pointer at its reset value.
    rst = 1'b1;
    step();
    check_reset_outputs("reset2");
    rst = 1'b0;
    f_req = 1'b1; f_addr = 10'h101; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
    mem_data = 16'h7777;
    for (int k = 0; k < 4; k++) begin
      int cyc;
      bit got;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 12) begin
        step();
        cyc++;
        if (f_ack || d_ack) got = 1'b1;
      end
      check($sformatf("tie%0d ack_seen", k), 32'(got), 32'd1);
      check($sformatf("tie%0d winner", k), 32'(d_ack), 32'(exp_tie[k]));
    end
    f_req = 1'b0; d_req = 1'b0;
    step();

    // Reset while in WAIT: access is dropped, nothing acks.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h2AA; mem_data = 16'h4444;
    step();
    check("rstwait grant", 32'(mem_en), 32'd1);
    step();
    check("rstwait in_wait", 32'({busy, mem_en}), 32'b10);
    rst = 1'b1; d_req = 1'b0;
    step();
    check_reset_outputs("rstwait");
    rst = 1'b0;
    f_req = 1'b1; f_addr = 10'h055; mem_data = 16'hC3C3;
    run_access("after_rst", 1'b0, 10'h055, 1'b0, 16'h0000);
    check("after_rst f_rdata", 32'(f_rdata), 32'h0000C3C3);
    f_req = 1'b0;
    step();

    // Fetch arrives while a data read is busy; it waits for the next IDLE.
    begin
      int cyc;
      int ens;
      cyc = 0; ens = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h022; mem_data = 16'h1111;
      while (!d_ack && cyc < 12) begin
        step();
        cyc++;
        if (mem_en) ens++;
        if (cyc == 1) begin
          f_req = 1'b1; f_addr = 10'h033;
        end
      end
      check("busyreq d_ack_cycle", 32'(cyc), 32'd3);
      check("busyreq d_mem_en_count", 32'(ens), 32'd1);
      check("busyreq f_ack_low", 32'(f_ack), 32'd0);
      check("busyreq d_rdata", 32'(d_rdata), 32'h00001111);
      d_req = 1'b0; mem_data = 16'h2222;
      step();
      check("busyreq idle_gap", 32'({busy, mem_en}), 32'd0);
      run_access("busyreq_fetch", 1'b0, 10'h033, 1'b0, 16'h0000);
      check("busyreq f_rdata", 32'(f_rdata), 32'h00002222);
      f_req = 1'b0;
      step();
    end

    // LAT=3 instance: data read acks in cycle 5 with data only valid in the third WAIT cycle.
    begin
      int cyc;
      int ens;
      cyc = 0; ens = 0;
      d_req3 = 1'b1; d_we = 1'b0; d_addr = 10'h0FF; mem_data = 16'h0ABC;
      while (!d_ack3 && cyc < 16) begin
        step();
        cyc++;
        if (mem_en3) ens++;
      end
      check("lat3 ack_cycle", 32'(cyc), 32'd5);
      check("lat3 mem_en_count", 32'(ens), 32'd1);
      check("lat3 f_ack_low", 32'(f_ack3), 32'd0);
      check("lat3 d_rdata", 32'(d_rdata3), 32'h00000ABC);
      d_req3 = 1'b0;
      step();
      check("lat3 idle", 32'(busy3), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Both acks high together can never be legal.
  always @(negedge clk) begin
    if (f_ack && d_ack) begin
      n_bad++;
      $display("FAIL dual_ack: got f_ack=1 d_ack=1, expected at most one");
    end
  end

endmodule
